// File: rtl/rr_burst_sched_pkg.sv
// -----------------------------------------------------------------------------
// rr_burst_sched_pkg
// Shared types and helpers for the round-robin burst scheduler.
//   state_t   : scheduler FSM state (ST_IDLE, ST_HOLD)
//   idx_width : width of a requester index / pointer, never below 1 bit
// -----------------------------------------------------------------------------
package rr_burst_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Purely combinational round-robin winner search.
// Ports:
//   req    (in)  : per-requester request vector
//   ptr    (in)  : index of the highest-priority requester this round
//   winner (out) : one-hot winner, all-zero when no request is present
//   idx    (out) : index of the winner, 0 when no request is present
// The search first looks only at requesters at or above ptr; if none of them
// request, it falls back to the plain lowest-index request (the wrap to 0).
// -----------------------------------------------------------------------------
module rr_priority_picker
    import rr_burst_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] idx
);

    logic [N-1:0] masked;
    logic         found;

    always_comb begin
        masked = '0;
        winner = '0;
        idx    = '0;
        found  = 1'b0;

        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] && (i >= int'(ptr));
        end

        for (int i = 0; i < N; i++) begin
            if (!found && masked[i]) begin
                winner[i] = 1'b1;
                idx       = IW'(i);
                found     = 1'b1;
            end
        end

        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                winner[i] = 1'b1;
                idx       = IW'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_burst_scheduler.sv
// -----------------------------------------------------------------------------
// rr_burst_scheduler
// Round-robin arbiter that grants a shared resource for a whole burst.
// Ports:
//   clk       (in)  : clock, rising edge
//   rst_n     (in)  : asynchronous active-low reset
//   req       (in)  : per-requester request, held for the whole burst
//   last      (in)  : per-requester final-beat marker
//   res_ready (in)  : resource accepts a beat this cycle
//   gnt       (out) : registered one-hot grant, zero when idle
//   gnt_id    (out) : index of the granted requester, 0 when idle
//   busy      (out) : a grant is held
//   timeout   (out) : one-cycle pulse on a forced release
// Optional feature: define RR_BURST_SCHED_TIMEOUT_EN to bound each grant
// tenure to MAX_HOLD cycles; without it timeout is tied low.
// -----------------------------------------------------------------------------
module rr_burst_scheduler
    import rr_burst_sched_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N-1:0]              req,
    input  logic [N-1:0]              last,
    input  logic                      res_ready,
    output logic [N-1:0]              gnt,
    output logic [idx_width(N)-1:0]   gnt_id,
    output logic                      busy,
    output logic                      timeout
);

    localparam int IW = idx_width(N);

    if (N < 2 || N > 16 || MAX_HOLD < 1) begin : g_bad_cfg
        $error("rr_burst_scheduler: unsupported N or MAX_HOLD");
    end

    state_t        state;
    logic [IW-1:0] ptr;

    logic          cur_req;
    logic          beat;
    logic          force_rel;
    logic          rel;
    logic          arbitrate;
    logic [IW-1:0] ptr_after_rel;
    logic [IW-1:0] arb_ptr;
    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;

    // A release happens on the final beat, when the holder drops its request
    // (abandon), or when the tenure limit forces it.
    always_comb begin
        cur_req       = req[gnt_id];
        beat          = cur_req && res_ready;
        rel           = (state == ST_HOLD) &&
                        (!cur_req || (beat && last[gnt_id]) || force_rel);
        ptr_after_rel = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);
        // Arbitration on the release cycle already uses the advanced pointer,
        // which leaves the releasing requester with the lowest priority.
        arb_ptr       = rel ? ptr_after_rel : ptr;
        arbitrate     = (state == ST_IDLE) || rel;
    end

    rr_priority_picker #(
        .N  (N),
        .IW (IW)
    ) u_picker (
        .req    (req),
        .ptr    (arb_ptr),
        .winner (pick_gnt),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
        end else begin
            if (rel) begin
                ptr <= ptr_after_rel;
            end
            if (arbitrate) begin
                if (|req) begin
                    state  <= ST_HOLD;
                    gnt    <= pick_gnt;
                    gnt_id <= pick_idx;
                    busy   <= 1'b1;
                end else begin
                    state  <= ST_IDLE;
                    gnt    <= '0;
                    gnt_id <= '0;
                    busy   <= 1'b0;
                end
            end
        end
    end

`ifdef RR_BURST_SCHED_TIMEOUT_EN
    localparam int CW = idx_width(MAX_HOLD + 1);

    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] cnt_next;
    logic          hold_next;

    // hold_cnt is the zero-based cycle number within the current tenure.
    // timeout is raised registered for the cycle whose number is MAX_HOLD-1,
    // and that same cycle forces the release.
    always_comb begin
        hold_next = arbitrate ? (|req) : 1'b1;
        cnt_next  = arbitrate ? '0 : hold_cnt + CW'(1);
    end

    assign force_rel = timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= cnt_next;
            timeout  <= hold_next && (cnt_next == CW'(MAX_HOLD - 1));
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rr_burst_scheduler
// Self-checking bench for rr_burst_scheduler with N=4, MAX_HOLD=4. A
// cycle-level reference model predicts the outputs for every driven cycle;
// predictions go through a scoreboard queue and are compared after the edge.
// -----------------------------------------------------------------------------
module tb_rr_burst_scheduler;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [3:0] req       = '0;
    logic [3:0] last      = '0;
    logic       res_ready = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       tmo;
    } exp_t;

    exp_t sbq[$];

    // reference model state
    logic [3:0] m_gnt;
    int         m_id;
    int         m_ptr;
    int         m_cnt;
    logic       m_tmo;

    rr_burst_scheduler #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .res_ready (res_ready),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic m_reset();
        m_gnt = '0;
        m_id  = 0;
        m_ptr = 0;
        m_cnt = 0;
        m_tmo = 1'b0;
    endtask

    // Predict the registered outputs after the coming edge.
    task automatic m_predict(input logic [3:0] r, input logic [3:0] l,
                             input logic rd, output exp_t e);
        bit hold;
        bit rel;
        int p;
        hold = (m_gnt != 4'b0000);
        rel  = 0;
        p    = m_ptr;
        if (hold)
            rel = !r[m_id] || (rd && l[m_id]) || m_tmo;
        if (rel) begin
            p     = (m_id + 1) % N;
            m_ptr = p;
        end
        if (!hold || rel) begin
            m_gnt = '0;
            m_id  = 0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (p + k) % N;
                if (m_gnt == 4'b0000 && r[c]) begin
                    m_gnt = 4'(1) << c;
                    m_id  = c;
                end
            end
            m_cnt = (m_gnt != 4'b0000) ? 1 : 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
        m_tmo = 1'b0;
`ifdef RR_BURST_SCHED_TIMEOUT_EN
        m_tmo = (m_gnt != 4'b0000) && (m_cnt == MAX_HOLD);
`endif
        e.gnt  = m_gnt;
        e.id   = 2'(m_id);
        e.busy = (m_gnt != 4'b0000);
        e.tmo  = m_tmo;
    endtask

    // Drive one cycle of stimulus, queue the prediction, advance past the edge.
    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rd);
        exp_t e;
        req       = r;
        last      = l;
        res_ready = rd;
        m_predict(r, l, rd, e);
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req       = '0;
        last      = '0;
        res_ready = 1'b0;
        rst_n     = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req   = 4'b1111;
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({gnt, gnt_id, busy, timeout} !== 8'b0) begin
            errors++;
            $display("FAIL reset_state: got gnt=%b id=%0d busy=%b tmo=%b, want all zero",
                     gnt, gnt_id, busy, timeout);
        end
        rst_n = 1'b1;
        req   = '0;
    endtask

    task automatic test_idle();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 4'b1111, 1'b1);
            e = sbq.pop_front();
            checks++;
            if ({gnt, gnt_id, busy, timeout} !== {e.gnt, e.id, e.busy, e.tmo} || gnt !== 4'b0000) begin
                errors++;
                $display("FAIL idle cyc%0d: got gnt=%b id=%0d busy=%b, want gnt=%b id=%0d busy=%b",
                         i, gnt, gnt_id, busy, e.gnt, e.id, e.busy);
            end
        end
    endtask

    task automatic test_single_persistent();
        exp_t e;
        logic [3:0] lseq [5];
        lseq = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'b0001, lseq[i], 1'b1);
            e = sbq.pop_front();
            checks++;
            if ({gnt, gnt_id, busy, timeout} !== {e.gnt, e.id, e.busy, e.tmo} || gnt !== 4'b0001) begin
                errors++;
                $display("FAIL single_persist cyc%0d: got gnt=%b busy=%b tmo=%b, want gnt=0001 busy=1 tmo=%b",
                         i + 1, gnt, busy, timeout, e.tmo);
            end
        end
    endtask

    task automatic test_rotation();
        exp_t e;
        logic [3:0] gseq [5];
        gseq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 4'b1111, 1'b1);
            e = sbq.pop_front();
            checks++;
            if ({gnt, gnt_id, busy, timeout} !== {e.gnt, e.id, e.busy, e.tmo} || gnt !== gseq[i]) begin
                errors++;
                $display("FAIL rotation grant%0d: got gnt=%b id=%0d, want gnt=%b id=%0d",
                         i, gnt, gnt_id, gseq[i], e.id);
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        logic [3:0] gseq [5];
        gseq = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 0)
                step(4'b0100, 4'b0000, 1'b0);
            else
                step(4'b1100, 4'b0100, (i == 4));
            e = sbq.pop_front();
            checks++;
            if ({gnt, gnt_id, busy, timeout} !== {e.gnt, e.id, e.busy, e.tmo} || gnt !== gseq[i]) begin
                errors++;
                $display("FAIL stall cyc%0d: got gnt=%b id=%0d tmo=%b, want gnt=%b id=%0d tmo=%b",
                         i, gnt, gnt_id, timeout, gseq[i], e.id, e.tmo);
            end
        end
    endtask

    task automatic test_ignore_last();
        exp_t e;
        logic [3:0] lseq [3];
        logic [3:0] gseq [3];
        lseq = '{4'b0000, 4'b0010, 4'b0001};
        gseq = '{4'b0001, 4'b0001, 4'b0010};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(4'b0011, lseq[i], 1'b1);
            e = sbq.pop_front();
            checks++;
            if ({gnt, gnt_id, busy, timeout} !== {e.gnt, e.id, e.busy, e.tmo} || gnt !== gseq[i]) begin
                errors++;
                $display("FAIL ignore_last cyc%0d: got gnt=%b, want gnt=%b", i, gnt, gseq[i]);
            end
        end
    endtask

    task automatic test_abandon();
        exp_t e;
        logic [3:0] rseq [3];
        logic [3:0] gseq [3];
        rseq = '{4'b1001, 4'b1001, 4'b1000};
        gseq = '{4'b0001, 4'b0001, 4'b1000};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(rseq[i], 4'b0000, 1'b1);
            e = sbq.pop_front();
            checks++;
            if ({gnt, gnt_id, busy, timeout} !== {e.gnt, e.id, e.busy, e.tmo} || gnt !== gseq[i]) begin
                errors++;
                $display("FAIL abandon cyc%0d: got gnt=%b id=%0d, want gnt=%b id=%0d",
                         i, gnt, gnt_id, gseq[i], e.id);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        do_reset();
        step(4'b1111, 4'b0000, 1'b1);
        step(4'b1111, 4'b0001, 1'b1);
        step(4'b0100, 4'b0000, 1'b1);
        repeat (3) void'(sbq.pop_front());
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_pre: got gnt=%b, want gnt=0100", gnt);
        end
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL midrst_async: got gnt=%b busy=%b id=%0d, want gnt=0000 busy=0 id=0",
                     gnt, busy, gnt_id);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b1100, 4'b0000, 1'b1);
        e = sbq.pop_front();
        checks++;
        if ({gnt, gnt_id, busy, timeout} !== {e.gnt, e.id, e.busy, e.tmo} || gnt !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_regrant: got gnt=%b id=%0d, want gnt=0100 id=2", gnt, gnt_id);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        logic tseq [6];
`ifdef RR_BURST_SCHED_TIMEOUT_EN
        tseq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        tseq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(4'b0010, 4'b0000, 1'b1);
            e = sbq.pop_front();
            checks++;
            if ({gnt, gnt_id, busy, timeout} !== {e.gnt, e.id, e.busy, e.tmo} ||
                gnt !== 4'b0010 || timeout !== tseq[i]) begin
                errors++;
                $display("FAIL timeout hold%0d: got gnt=%b tmo=%b, want gnt=0010 tmo=%b",
                         i + 1, gnt, timeout, tseq[i]);
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            e = sbq.pop_front();
            checks++;
            if ({gnt, gnt_id, busy, timeout} !== {e.gnt, e.id, e.busy, e.tmo}) begin
                errors++;
                $display("FAIL random cyc%0d: got gnt=%b id=%0d busy=%b tmo=%b, want gnt=%b id=%0d busy=%b tmo=%b",
                         i, gnt, gnt_id, busy, timeout, e.gnt, e.id, e.busy, e.tmo);
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_idle();
        test_single_persistent();
        test_rotation();
        test_stall();
        test_ignore_last();
        test_abandon();
        test_reset_mid_burst();
        test_timeout();
        test_random();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
